oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 15 +
 rtl/oam_dma.sv | 107 ++++++++++
 tb/tb_oam_dma.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: the state encoding and default
// register address / transfer length.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_REG_ADDR = 16'hFF46;
  localparam int          DEFAULT_XFER_LEN = 160;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to REG_ADDR copies XFER_LEN bytes from page {src,00}
// into OAM. Optional macro OAM_DMA_ECHO_REMAP_EN folds echo pages E0-FF onto C0-DF.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = DEFAULT_REG_ADDR,
  parameter int          XFER_LEN = DEFAULT_XFER_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_tick,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] dma_addr_bus,
  output logic        dma_rd,
  output logic        mem_ctrl_sel,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_wr,
  output logic [7:0]  dma_reg,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] wr_idx;
  logic [7:0] data_q;
  logic       pending;
  logic       trigger;
  logic [7:0] page;

  assign trigger = cpu_wr && (cpu_addr == REG_ADDR);

  // The trigger is honoured on any edge and overrides the M-cycle step, so a
  // rewrite mid-transfer restarts cleanly and drops the pending OAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src     <= 8'h00;
      idx     <= 8'h00;
      wr_idx  <= 8'h00;
      data_q  <= 8'h00;
      pending <= 1'b0;
    end else if (trigger) begin
      state   <= START;
      src     <= cpu_data;
      idx     <= 8'h00;
      pending <= 1'b0;
    end else if (m_tick) begin
      case (state)
        START: begin
          state   <= XFER;
          idx     <= 8'h00;
          pending <= 1'b0;
        end
        XFER: begin
          data_q  <= mem_data_in;
          wr_idx  <= idx;
          pending <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= DRAIN;
            idx   <= 8'h00;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        DRAIN: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    page = src;
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (src[7:5] == 3'b111) page[5] = 1'b0;
`endif
  end

  // The OAM write of byte i overlaps the read of byte i+1 on a separate port.
  always_comb begin
    dma_addr_bus = 16'h0000;
    dma_rd       = 1'b0;
    mem_ctrl_sel = 1'b0;
    if (state == XFER) begin
      dma_addr_bus = {page, idx};
      dma_rd       = 1'b1;
      mem_ctrl_sel = 1'b1;
    end
    oam_wr   = pending;
    oam_addr = pending ? wr_idx : 8'h00;
    oam_data = pending ? data_q : 8'h00;
    busy     = (state != IDLE);
    dma_reg  = src;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: behavioural source memory and OAM array models,
// a table of CPU writes, and hand-written restart / reset corner cases.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_tick = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic [7:0]  mem_data_in;
  logic [15:0] dma_addr_bus;
  logic        dma_rd;
  logic        mem_ctrl_sel;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_wr;
  logic [7:0]  dma_reg;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  oam_dma dut (
    .clk(clk), .rst(rst), .m_tick(m_tick),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr),
    .mem_data_in(mem_data_in),
    .dma_addr_bus(dma_addr_bus), .dma_rd(dma_rd), .mem_ctrl_sel(mem_ctrl_sel),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_wr(oam_wr),
    .dma_reg(dma_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  // One M-cycle is four clocks; m_tick marks the last of them.
  logic [1:0] tcnt = 2'd0;
  always @(posedge clk) begin
    #2;
    tcnt = tcnt + 2'd1;
    m_tick = (tcnt == 2'd3);
  end

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
  endfunction

  always_comb mem_data_in = mem_model(dma_addr_bus);

  int          mcyc = 0;
  int          rd_cnt, wr_cnt, busy_cyc, first_rd_cyc, last_rd_cyc, last_wr_cyc;
  logic [15:0] first_rd_addr, last_rd_addr;
  logic [7:0]  oam [256];
  int          hits [256];
  logic        bad40;
  logic        stat_clr = 1'b0;

  always @(posedge clk) begin
    if (m_tick) mcyc <= mcyc + 1;
    if (stat_clr) begin
      rd_cnt <= 0; wr_cnt <= 0; busy_cyc <= 0; bad40 <= 1'b0;
      first_rd_cyc <= 0; last_rd_cyc <= 0; last_wr_cyc <= 0;
      first_rd_addr <= 16'h0; last_rd_addr <= 16'h0;
      for (int i = 0; i < 256; i++) begin
        oam[i]  <= 8'h00;
        hits[i] <= 0;
      end
    end else if (m_tick) begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (dma_rd) begin
        if (rd_cnt == 0) begin
          first_rd_addr <= dma_addr_bus;
          first_rd_cyc  <= mcyc;
        end
        last_rd_addr <= dma_addr_bus;
        last_rd_cyc  <= mcyc;
        rd_cnt       <= rd_cnt + 1;
      end
      if (oam_wr) begin
        oam[oam_addr]  <= oam_data;
        hits[oam_addr] <= hits[oam_addr] + 1;
        wr_cnt         <= wr_cnt + 1;
        last_wr_cyc    <= mcyc;
        if (oam_addr == 8'd40 && oam_data == mem_model(16'hC128)) bad40 <= 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  function automatic int oam_errors(input logic [7:0] hi, input logic need_single);
    int n = 0;
    for (int i = 0; i < 160; i++) begin
      if (oam[i] !== mem_model({hi, 8'(i)})) n++;
      else if (need_single && hits[i] != 1) n++;
    end
    return n;
  endfunction

  task automatic clear_stats();
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
  endtask

  // Writes on the last T-cycle of an M-cycle; trig_w is that M-cycle's number.
  task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data,
                                output int trig_w);
    int n = 0;
    @(negedge clk);
    while (!m_tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    cpu_addr = addr;
    cpu_data = data;
    cpu_wr   = 1'b1;
    trig_w   = mcyc;
    @(posedge clk);
    #1;
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_idle: actual busy=1 required busy=0 within 1000 clocks");
    end
    repeat (8) @(negedge clk);
  endtask

  // Returns at the negedge of the last T-cycle of the M-cycle reading byte target.
  task automatic wait_idx(input logic [7:0] target);
    int n = 0;
    @(negedge clk);
    while (!(dma_rd && dma_addr_bus[7:0] == target && m_tick) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_idx: actual no read of index %0d required one", target);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_busy;
    logic [7:0]  exp_reg;
    int          exp_reads;
    logic [7:0]  exp_hi;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          trig_w;
    logic [7:0]  echo_hi;
    logic        start_wr;
    int          n;

    rst = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs",
      {dma_addr_bus, dma_rd, mem_ctrl_sel, oam_addr, oam_data, oam_wr, dma_reg, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef OAM_DMA_ECHO_REMAP_EN
    echo_hi = 8'hC3;
`else
    echo_hi = 8'hE3;
`endif
    vecs[0] = '{16'hFF45, 8'hAA, 1'b0, 8'h00, 0,   8'h00};
    vecs[1] = '{16'hFF47, 8'h55, 1'b0, 8'h00, 0,   8'h00};
    vecs[2] = '{16'hFF46, 8'hC1, 1'b1, 8'hC1, 160, 8'hC1};
    vecs[3] = '{16'hFF46, 8'h80, 1'b1, 8'h80, 160, 8'h80};
    vecs[4] = '{16'hFF46, 8'hE3, 1'b1, 8'hE3, 160, echo_hi};
    vecs[5] = '{16'hFF45, 8'h12, 1'b0, 8'hE3, 0,   8'h00};

    for (int v = 0; v < 6; v++) begin
      clear_stats();
      apply_stimulus(vecs[v].addr, vecs[v].data, trig_w);
      check_output($sformatf("v%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
      check_output($sformatf("v%0d_dma_reg", v), 64'(dma_reg), 64'(vecs[v].exp_reg));
      check_output($sformatf("v%0d_sel_start", v), 64'(mem_ctrl_sel), 64'h0);
      wait_idle();
      check_output($sformatf("v%0d_reads", v), 64'(rd_cnt), 64'(vecs[v].exp_reads));
      check_output($sformatf("v%0d_writes", v), 64'(wr_cnt), 64'(vecs[v].exp_reads));
      check_output($sformatf("v%0d_dma_reg_after", v), 64'(dma_reg), 64'(vecs[v].exp_reg));
      if (vecs[v].exp_reads > 0) begin
        check_output($sformatf("v%0d_first_addr", v), 64'(first_rd_addr), 64'({vecs[v].exp_hi, 8'h00}));
        check_output($sformatf("v%0d_last_addr", v), 64'(last_rd_addr), 64'({vecs[v].exp_hi, 8'h9F}));
        check_output($sformatf("v%0d_first_rd_lat", v), 64'(first_rd_cyc - trig_w), 64'd2);
        check_output($sformatf("v%0d_last_rd_lat", v), 64'(last_rd_cyc - trig_w), 64'd161);
        check_output($sformatf("v%0d_last_wr_lat", v), 64'(last_wr_cyc - trig_w), 64'd162);
        check_output($sformatf("v%0d_busy_cycles", v), 64'(busy_cyc), 64'd162);
        check_output($sformatf("v%0d_oam_errors", v), 64'(oam_errors(vecs[v].exp_hi, 1'b1)), 64'd0);
      end
    end

    // Restart at index 40 with a trigger coinciding with m_tick.
    clear_stats();
    apply_stimulus(16'hFF46, 8'hC1, trig_w);
    wait_idx(8'd40);
    cpu_addr = 16'hFF46; cpu_data = 8'hD0; cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;
    check_output("restart_busy", 64'(busy), 64'h1);
    check_output("restart_sel", 64'(mem_ctrl_sel), 64'h0);
    check_output("restart_rd_addr", 64'({dma_rd, dma_addr_bus}), 64'h0);
    check_output("restart_dma_reg", 64'(dma_reg), 64'hD0);
    start_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (oam_wr) start_wr = 1'b1;
    end
    check_output("restart_no_oam_wr", 64'(start_wr), 64'h0);
    @(posedge clk);
    #1;
    check_output("restart_first_addr", 64'(dma_addr_bus), 64'hD000);
    check_output("restart_first_oam_wr", 64'(oam_wr), 64'h0);
    wait_idle();
    check_output("restart_writes", 64'(wr_cnt), 64'd200);
    check_output("restart_no_stale_40", 64'(bad40), 64'h0);
    check_output("restart_oam_errors", 64'(oam_errors(8'hD0, 1'b0)), 64'd0);

    // Reset in the middle of a transfer.
    clear_stats();
    apply_stimulus(16'hFF46, 8'hC1, trig_w);
    wait_idx(8'd100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_outputs",
      {dma_addr_bus, dma_rd, mem_ctrl_sel, oam_addr, oam_data, oam_wr, dma_reg, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (400) @(negedge clk);
    check_output("abort_reads_after", 64'(rd_cnt), 64'd0);
    check_output("abort_writes_after", 64'(wr_cnt), 64'd0);
    check_output("abort_busy_after", 64'(busy), 64'h0);

    // Reset and trigger on the same edge.
    apply_stimulus(16'hFF46, 8'h00, trig_w);
    wait_idle();
    @(negedge clk);
    rst = 1'b1; cpu_addr = 16'hFF46; cpu_data = 8'h77; cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;
    check_output("rst_vs_trig_busy", 64'(busy), 64'h0);
    check_output("rst_vs_trig_reg", 64'(dma_reg), 64'h00);

    // Trigger on an edge without m_tick still takes effect.
    n = 0;
    @(negedge clk);
    while (m_tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    cpu_addr = 16'hFF46; cpu_data = 8'h42; cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0;
    check_output("midcycle_busy", 64'(busy), 64'h1);
    check_output("midcycle_reg", 64'(dma_reg), 64'h42);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
